// File: rtl/bst_pkg.sv
// Shared definitions for the binary-search-tree key store.
// Holds the fixed capacity/width constants, the node record stored per
// slot, and the reserved key value that turns an insert into clear-all.
package bst_pkg;

    localparam int NODES = 8;
    localparam int KEY_W = 4;
    localparam int IDX_W = 3;
    localparam int CNT_W = IDX_W + 1;    // must reach NODES itself (full)

    localparam logic [KEY_W-1:0] CLEAR_KEY = '0;

    // One tree node. Child indices are meaningful only while the matching
    // valid flag is set.
    typedef struct packed {
        logic [KEY_W-1:0] key;
        logic             lval;
        logic [IDX_W-1:0] lidx;
        logic             rval;
        logic [IDX_W-1:0] ridx;
    } node_t;

endpackage

// File: rtl/bst_store_if.sv
// Command/result bundle of the key store.
//   k0           find command (level sampled)
//   k1           insert, or clear-all when sw == CLEAR_KEY (level sampled)
//   sw           key operand
//   led          find result {hit, slot[2:0], key[3:0]}
//   buf_empty    no node stored
//   buf_full     NODES nodes stored
//   tree_counter next free slot (stored count mod NODES)
// Handshake: there is no valid/ready pair; every rising clock edge where
// k0 or k1 is high performs exactly one operation, and the result is
// visible on the outputs right after that edge.
interface bst_store_if;
    import bst_pkg::*;

    logic             k0;
    logic             k1;
    logic [KEY_W-1:0] sw;
    logic [7:0]       led;
    logic             buf_empty;
    logic             buf_full;
    logic [IDX_W-1:0] tree_counter;

    modport master (
        output k0, k1, sw,
        input  led, buf_empty, buf_full, tree_counter
    );

    modport slave (
        input  k0, k1, sw,
        output led, buf_empty, buf_full, tree_counter
    );

endinterface

// File: rtl/bst_walk.sv
// Combinational tree search shared by find and insert.
//   nodes_i      node array (slot 0 is the root)
//   count_i      number of stored nodes; 0 means the tree is empty
//   key_i        key being looked up
//   hit_o        key found
//   hit_idx_o    slot of the matching node (0 on miss)
//   parent_idx_o last node visited (the attach point on a miss)
//   go_left_o    on a miss, the new key belongs in the left child of parent
module bst_walk
    import bst_pkg::*;
(
    input  node_t            nodes_i [NODES],
    input  logic [CNT_W-1:0] count_i,
    input  logic [KEY_W-1:0] key_i,
    output logic             hit_o,
    output logic [IDX_W-1:0] hit_idx_o,
    output logic [IDX_W-1:0] parent_idx_o,
    output logic             go_left_o
);

    logic [IDX_W-1:0] cur;
    logic             done;

    // A tree of NODES nodes is at most NODES levels deep, so an unrolled
    // walk of NODES steps always terminates on a hit or an empty child.
    always_comb begin
        hit_o        = 1'b0;
        hit_idx_o    = '0;
        parent_idx_o = '0;
        go_left_o    = 1'b0;
        cur          = '0;
        done         = (count_i == '0);
        for (int lvl = 0; lvl < NODES; lvl++) begin
            if (!done) begin
                parent_idx_o = cur;
                if (key_i == nodes_i[cur].key) begin
                    hit_o     = 1'b1;
                    hit_idx_o = cur;
                    done      = 1'b1;
                end else if (key_i < nodes_i[cur].key) begin
                    go_left_o = 1'b1;
                    if (nodes_i[cur].lval) cur = nodes_i[cur].lidx;
                    else                   done = 1'b1;
                end else begin
                    go_left_o = 1'b0;
                    if (nodes_i[cur].rval) cur = nodes_i[cur].ridx;
                    else                   done = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/bst_store.sv
// Binary-search-tree key store: up to NODES 4-bit keys, one-cycle
// find / insert / clear-all commands, find result latched onto led.
//   clk  system clock, all state changes on the rising edge
//   rst  synchronous active-high reset
//   bus  command/result bundle (slave side), see bst_store_if
// Command priority: rst > k1 > k0; led only changes on a find.
module bst_store
    import bst_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    bst_store_if.slave  bus
);

    node_t            nodes_q [NODES];
    node_t            nodes_d [NODES];
    logic [CNT_W-1:0] count_q, count_d;
    logic [7:0]       led_q, led_d;

    logic             hit;
    logic [IDX_W-1:0] hit_idx;
    logic             full;
    logic [IDX_W-1:0] parent_idx;
    logic             go_left;
    logic [IDX_W-1:0] new_idx;

    bst_walk u_walk (
        .nodes_i      (nodes_q),
        .count_i      (count_q),
        .key_i        (bus.sw),
        .hit_o        (hit),
        .hit_idx_o    (hit_idx),
        .parent_idx_o (parent_idx),
        .go_left_o    (go_left)
    );

    assign full    = (count_q == CNT_W'(NODES));
    assign new_idx = count_q[IDX_W-1:0];

    always_comb begin
        nodes_d = nodes_q;
        count_d = count_q;
        led_d   = led_q;
        if (bus.k1) begin
            if (bus.sw == CLEAR_KEY) begin
                // Dropping the count and child links is enough: stale keys
                // are unreachable until overwritten by a later insert.
                count_d = '0;
                for (int i = 0; i < NODES; i++) begin
                    nodes_d[i].lval = 1'b0;
                    nodes_d[i].rval = 1'b0;
                end
            end else if (!full && !hit) begin
                nodes_d[new_idx] = '{key: bus.sw, default: '0};
                // Root has no parent; every later node hangs off the last
                // node the walk visited.
                if (count_q != '0) begin
                    if (go_left) begin
                        nodes_d[parent_idx].lval = 1'b1;
                        nodes_d[parent_idx].lidx = new_idx;
                    end else begin
                        nodes_d[parent_idx].rval = 1'b1;
                        nodes_d[parent_idx].ridx = new_idx;
                    end
                end
                count_d = count_q + CNT_W'(1);
            end
        end else if (bus.k0) begin
            led_d = {hit, hit_idx, bus.sw};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
            led_q   <= '0;
            for (int i = 0; i < NODES; i++) nodes_q[i] <= '0;
        end else begin
            count_q <= count_d;
            led_q   <= led_d;
            nodes_q <= nodes_d;
        end
    end

    assign bus.led          = led_q;
    assign bus.buf_empty    = (count_q == '0);
    assign bus.buf_full     = full;
    assign bus.tree_counter = count_q[IDX_W-1:0];

endmodule

// File: tb/tb_bst_store.sv
// Bench for bst_store. The reference model keeps the stored keys as a plain
// list in insertion order: a key's slot is simply its position in that list,
// so hits and slot numbers are derived without modelling any tree walk.
module tb_bst_store;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_errors;

    bst_store_if bus ();

    bst_store dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // reference model
    logic [3:0] m_keys[$];
    logic [7:0] m_led;

    function automatic int m_find(input logic [3:0] k);
        for (int i = 0; i < m_keys.size(); i++)
            if (m_keys[i] == k) return i;
        return -1;
    endfunction

    function automatic logic [13:0] m_expected();
        int n;
        n = m_keys.size();
        return {m_led, 1'b0, (n == 0), (n == 8), 3'(n % 8)};
    endfunction

    function automatic logic [13:0] observed();
        return {bus.led, 1'b0, bus.buf_empty, bus.buf_full, bus.tree_counter};
    endfunction

    // Drive one clock edge with the given inputs, then update the model.
    task automatic step(input logic r, input logic c0, input logic c1, input logic [3:0] k);
        int idx;
        @(negedge clk);
        rst = r; bus.k0 = c0; bus.k1 = c1; bus.sw = k;
        @(posedge clk);
        #1;
        rst = 1'b0; bus.k0 = 1'b0; bus.k1 = 1'b0;
        if (r) begin
            m_keys.delete();
            m_led = 8'h00;
        end else if (c1) begin
            if (k == 4'd0) m_keys.delete();
            else if (m_keys.size() < 8 && m_find(k) < 0) m_keys.push_back(k);
        end else if (c0) begin
            idx = m_find(k);
            m_led = (idx >= 0) ? {1'b1, 3'(idx), k} : {4'b0000, k};
        end
    endtask

    task automatic test_reset();
        step(1'b1, 1'b0, 1'b0, 4'd0);
        step(1'b1, 1'b0, 1'b0, 4'd0);
        n_checks++;
        if (observed() !== 14'b00000000_0_1_0_000) begin
            n_errors++;
            $display("FAIL reset_state: got %h want %h", observed(), 14'b00000000_0_1_0_000);
        end
        step(1'b0, 1'b1, 1'b0, 4'd5);
        n_checks++;
        if (observed() !== m_expected() || bus.led[7] !== 1'b0) begin
            n_errors++;
            $display("FAIL find_empty: got %h want %h", observed(), m_expected());
        end
    endtask

    task automatic test_fill();
        logic [3:0] seq [8] = '{4'd5, 4'd11, 4'd9, 4'd3, 4'd1, 4'd13, 4'd7, 4'd15};
        for (int i = 0; i < 8; i++) begin
            step(1'b0, 1'b0, 1'b1, seq[i]);
            n_checks++;
            if (observed() !== m_expected()) begin
                n_errors++;
                $display("FAIL fill_insert_%0d: got %h want %h", i, observed(), m_expected());
            end
        end
        for (int i = 0; i < 8; i++) begin
            step(1'b0, 1'b1, 1'b0, seq[i]);
            n_checks++;
            if (observed() !== m_expected() || bus.led !== {1'b1, 3'(i), seq[i]}) begin
                n_errors++;
                $display("FAIL fill_find_%0d: got led %h want %h", i, bus.led, {1'b1, 3'(i), seq[i]});
            end
        end
        n_checks++;
        if (bus.buf_full !== 1'b1 || bus.tree_counter !== 3'd0) begin
            n_errors++;
            $display("FAIL full_flags: got full=%b cnt=%0d want full=1 cnt=0", bus.buf_full, bus.tree_counter);
        end
    endtask

    task automatic test_full_ignore();
        step(1'b0, 1'b0, 1'b1, 4'd2);
        n_checks++;
        if (observed() !== m_expected()) begin
            n_errors++;
            $display("FAIL full_insert: got %h want %h", observed(), m_expected());
        end
        step(1'b0, 1'b1, 1'b0, 4'd2);
        n_checks++;
        if (bus.led !== 8'h02) begin
            n_errors++;
            $display("FAIL full_find_miss: got led %h want 02", bus.led);
        end
    endtask

    task automatic test_clear();
        step(1'b0, 1'b0, 1'b1, 4'd0);
        n_checks++;
        if (observed() !== m_expected() || bus.buf_empty !== 1'b1) begin
            n_errors++;
            $display("FAIL clear: got %h want %h", observed(), m_expected());
        end
        step(1'b0, 1'b1, 1'b0, 4'd13);
        n_checks++;
        if (bus.led !== 8'h0d) begin
            n_errors++;
            $display("FAIL clear_find: got led %h want 0d", bus.led);
        end
    endtask

    task automatic test_duplicate();
        step(1'b0, 1'b0, 1'b1, 4'd5);
        step(1'b0, 1'b0, 1'b1, 4'd11);
        step(1'b0, 1'b0, 1'b1, 4'd9);
        step(1'b0, 1'b0, 1'b1, 4'd9);
        n_checks++;
        if (bus.tree_counter !== 3'd3 || observed() !== m_expected()) begin
            n_errors++;
            $display("FAIL duplicate: got cnt=%0d want 3", bus.tree_counter);
        end
    endtask

    task automatic test_back_to_back();
        step(1'b0, 1'b0, 1'b1, 4'd0);
        step(1'b0, 1'b0, 1'b1, 4'd8);
        step(1'b0, 1'b1, 1'b0, 4'd8);
        n_checks++;
        if (bus.led !== 8'h88) begin
            n_errors++;
            $display("FAIL insert_then_find: got led %h want 88", bus.led);
        end
    endtask

    task automatic test_both_cmds();
        logic [7:0] led_before;
        led_before = bus.led;
        step(1'b0, 1'b1, 1'b1, 4'd4);
        n_checks++;
        if (bus.led !== led_before || observed() !== m_expected()) begin
            n_errors++;
            $display("FAIL both_cmds: got %h want %h", observed(), m_expected());
        end
        step(1'b0, 1'b1, 1'b0, 4'd4);
        n_checks++;
        if (bus.led !== 8'h94) begin
            n_errors++;
            $display("FAIL both_cmds_find: got led %h want 94", bus.led);
        end
    endtask

    task automatic test_random();
        int op;
        logic [3:0] k;
        for (int i = 0; i < 300; i++) begin
            op = $urandom_range(0, 19);
            k  = 4'($urandom_range(1, 15));
            if (op == 0)       step(1'b0, 1'b0, 1'b1, 4'd0);
            else if (op < 9)   step(1'b0, 1'b0, 1'b1, k);
            else if (op < 18)  step(1'b0, 1'b1, 1'b0, k);
            else if (op == 18) step(1'b0, 1'b1, 1'b1, k);
            else               step(1'b0, 1'b0, 1'b0, k);
            n_checks++;
            if (observed() !== m_expected()) begin
                n_errors++;
                $display("FAIL random_%0d op=%0d sw=%0d: got %h want %h", i, op, k, observed(), m_expected());
            end
        end
    endtask

    task automatic test_reset_mid();
        step(1'b0, 1'b0, 1'b1, 4'd6);
        step(1'b1, 1'b0, 1'b1, 4'd7);
        n_checks++;
        if (observed() !== m_expected() || bus.buf_empty !== 1'b1) begin
            n_errors++;
            $display("FAIL reset_mid: got %h want %h", observed(), m_expected());
        end
        step(1'b0, 1'b1, 1'b0, 4'd6);
        n_checks++;
        if (bus.led !== 8'h06) begin
            n_errors++;
            $display("FAIL reset_mid_find: got led %h want 06", bus.led);
        end
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        m_led    = 8'h00;
        rst      = 1'b1;
        bus.k0   = 1'b0;
        bus.k1   = 1'b0;
        bus.sw   = 4'd0;
        test_reset();
        test_fill();
        test_full_ignore();
        test_clear();
        test_duplicate();
        test_back_to_back();
        test_both_cmds();
        test_random();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
